// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, false-start rejection, framing-error flag.
// Latency: done/frame_err one cycle after the stop sample (T0 + cpb/2 + 9*cpb + 1); no backpressure, the byte is held on data_bus until the next good frame.
`timescale 1ns/1ps
module uart_rx #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [12:0]           CLKS_PER_BIT,
    input  logic                  data_bit,
    output logic [data_width-1:0] data_bus,
    output logic                  done,
    output logic                  frame_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic                  rx_q, rx_d;
    logic [12:0]           cpb_l_q, cpb_l_d;
    logic [12:0]           clk_counter_q, clk_counter_d;
    logic [2:0]            bit_counter_q, bit_counter_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic [data_width-1:0] data_bus_q, data_bus_d;
    logic                  done_q, done_d;
    logic                  frame_err_q, frame_err_d;

    logic        rx_s;
    logic        fall;
    logic [12:0] half;

    always_comb begin
        sync_d        = {sync_q[0], data_bit};
        rx_s          = sync_q[1];
        rx_d          = rx_s;
        fall          = rx_q & ~rx_s;
        half          = cpb_l_q >> 1;
        state_d       = state_q;
        cpb_l_d       = cpb_l_q;
        clk_counter_d = clk_counter_q;
        bit_counter_d = bit_counter_q;
        shift_d       = shift_q;
        data_bus_d    = data_bus_q;
        done_d        = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a fresh high-to-low edge arms the receiver; a held-low line is ignored.
                if (fall) begin
                    cpb_l_d       = CLKS_PER_BIT;
                    clk_counter_d = '0;
                    state_d       = START_BIT;
                end
            end
            START_BIT: begin
                if (clk_counter_q == half - 13'd1) begin
                    if (!rx_s) begin
                        clk_counter_d = '0;
                        bit_counter_d = '0;
                        state_d       = DATA_BITS;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_counter_d = clk_counter_q + 13'd1;
                end
            end
            DATA_BITS: begin
                if (clk_counter_q == cpb_l_q - 13'd1) begin
                    shift_d[bit_counter_q] = rx_s;
                    clk_counter_d          = '0;
                    if (bit_counter_q == 3'(data_width - 1)) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_counter_d = bit_counter_q + 3'd1;
                    end
                end else begin
                    clk_counter_d = clk_counter_q + 13'd1;
                end
            end
            STOP_BIT: begin
                if (clk_counter_q == cpb_l_q - 13'd1) begin
                    clk_counter_d = '0;
                    if (rx_s) begin
                        data_bus_d = shift_q;
                        done_d     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    clk_counter_d = clk_counter_q + 13'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            rx_q          <= 1'b1;
            cpb_l_q       <= '0;
            clk_counter_q <= '0;
            bit_counter_q <= '0;
            shift_q       <= '0;
            data_bus_q    <= '0;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            rx_q          <= rx_d;
            cpb_l_q       <= cpb_l_d;
            clk_counter_q <= clk_counter_d;
            bit_counter_q <= bit_counter_d;
            shift_q       <= shift_d;
            data_bus_q    <= data_bus_d;
            done_q        <= done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign data_bus  = data_bus_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitch, framing error, back-to-back, mid-frame reset, runtime bit-period change.
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [12:0] cpb_in = 13'd16;
    logic        data_bit = 1'b1;
    logic [7:0]  data_bus;
    logic        done;
    logic        frame_err;
    logic        busy;

    uart_rx #(.data_width(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .CLKS_PER_BIT (cpb_in),
        .data_bit     (data_bit),
        .data_bus     (data_bus),
        .done         (done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       done_cnt = 0;
    int       ferr_cnt = 0;
    int       both_cnt = 0;
    int       last_done_cyc = -1;
    int       last_ferr_cyc = -1;
    logic [7:0] last_dat = 8'h00;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
            last_dat      = data_bus;
        end
        if (frame_err === 1'b1) begin
            ferr_cnt      = ferr_cnt + 1;
            last_ferr_cyc = cyc;
        end
        if (done === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge; s is the cycle index at which the start bit was applied.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop,
                              input int cpb_mid, output int s);
        cpb_in   = 13'(cpb);
        s        = cyc;
        data_bit = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            data_bit = b[i];
            if (i == 3 && cpb_mid != 0) cpb_in = 13'(cpb_mid);
            repeat (cpb) @(negedge clk);
        end
        data_bit = stop;
        repeat (cpb) @(negedge clk);
    endtask

    int s;
    int d0;
    int f0;
    logic [7:0] ab;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_bus", 32'(data_bus), 32'h00);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // 1: good frame 0xA5 at 16 clocks/bit
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 16, 1'b1, 0, s);
        chk("t1_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        chk("t1_done_cyc", 32'(last_done_cyc), 32'(s + 155));
        chk("t1_data", 32'(last_dat), 32'hA5);
        chk("t1_ferr_cnt", 32'(ferr_cnt), 32'(f0));
        repeat (20) @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_data_hold", 32'(data_bus), 32'hA5);

        // 2: 4-clock low glitch on idle line
        d0 = done_cnt; f0 = ferr_cnt;
        data_bit = 1'b0;
        repeat (4) @(negedge clk);
        data_bit = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_busy_in_start", 32'(busy), 32'h1);
        repeat (40) @(negedge clk);
        chk("t2_busy_after", 32'(busy), 32'h0);
        chk("t2_done_cnt", 32'(done_cnt), 32'(d0));
        chk("t2_ferr_cnt", 32'(ferr_cnt), 32'(f0));
        chk("t2_data", 32'(data_bus), 32'hA5);

        // 3: 0x3C with stop bit low, line left low afterwards
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 16, 1'b0, 0, s);
        chk("t3_ferr_cnt", 32'(ferr_cnt), 32'(f0 + 1));
        chk("t3_ferr_cyc", 32'(last_ferr_cyc), 32'(s + 155));
        chk("t3_done_cnt", 32'(done_cnt), 32'(d0));
        chk("t3_data", 32'(data_bus), 32'hA5);
        repeat (200) @(negedge clk);
        chk("t3_busy_low_line", 32'(busy), 32'h0);
        chk("t3_ferr_once", 32'(ferr_cnt), 32'(f0 + 1));
        data_bit = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_busy_rise", 32'(busy), 32'h0);

        // 4: back-to-back 0x00 then 0xFF at 433 clocks/bit
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 433, 1'b1, 0, s);
        chk("t4_done_cnt_a", 32'(done_cnt), 32'(d0 + 1));
        chk("t4_done_cyc_a", 32'(last_done_cyc), 32'(s + 3 + 216 + 9 * 433));
        chk("t4_data_a", 32'(last_dat), 32'h00);
        send_frame(8'hFF, 433, 1'b1, 0, s);
        chk("t4_done_cnt_b", 32'(done_cnt), 32'(d0 + 2));
        chk("t4_done_cyc_b", 32'(last_done_cyc), 32'(s + 3 + 216 + 9 * 433));
        chk("t4_data_b", 32'(last_dat), 32'hFF);
        chk("t4_ferr_cnt", 32'(ferr_cnt), 32'(f0));

        // 5: reset during data bit 3 of 0x55, then 0x12
        repeat (10) @(negedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        ab = 8'h55;
        cpb_in = 13'd16;
        data_bit = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            data_bit = ab[i];
            repeat (16) @(negedge clk);
        end
        data_bit = ab[3];
        repeat (8) @(negedge clk);
        chk("t5_busy_mid", 32'(busy), 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_data", 32'(data_bus), 32'h00);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        data_bit = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        chk("t5_no_ferr", 32'(ferr_cnt), 32'(f0));
        send_frame(8'h12, 16, 1'b1, 0, s);
        chk("t5_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        chk("t5_done_cyc", 32'(last_done_cyc), 32'(s + 155));
        chk("t5_data", 32'(last_dat), 32'h12);

        // 6: 0x81 at 17 with port changed to 40 mid-frame, then 0x5A at 40
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        send_frame(8'h81, 17, 1'b1, 40, s);
        chk("t6_done_cnt_a", 32'(done_cnt), 32'(d0 + 1));
        chk("t6_done_cyc_a", 32'(last_done_cyc), 32'(s + 3 + 8 + 9 * 17));
        chk("t6_data_a", 32'(last_dat), 32'h81);
        send_frame(8'h5A, 40, 1'b1, 0, s);
        chk("t6_done_cnt_b", 32'(done_cnt), 32'(d0 + 2));
        chk("t6_done_cyc_b", 32'(last_done_cyc), 32'(s + 3 + 20 + 9 * 40));
        chk("t6_data_b", 32'(last_dat), 32'h5A);

        repeat (10) @(negedge clk);
        chk("never_both", 32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that pairs with the existing uart_tx transmitter. It deserialises one 8N1 frame from an asynchronous serial line into a parallel byte, using the same runtime CLKS_PER_BIT bit-period input as the transmitter. It sits on the chip's serial input pin and feeds the byte to the core logic with a one-cycle done strobe. The block uses mid-bit sampling, rejects false start bits and flags framing errors.

Parameters:
data_width, 8, number of data bits per frame (LSB first); the state machine and tests cover 8 only.

Ports:
clk  input  1  system clock; all flops are rising-edge.
rstn  input  1  asynchronous active-low reset.
CLKS_PER_BIT  input  13  clocks per bit period; valid range 4..8191; latched at start detection.
data_bit  input  1  serial line, asynchronous to clk, idles high.
data_bus  output  data_width  last correctly received byte; holds between frames.
done  output  1  one-cycle pulse when a good frame is received and data_bus is updated.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, data_bus=0, done=0, frame_err=0, busy=0.
  - Counters and shift register are cleared.
  - Both synchroniser flops are set to 1, so no false edge is seen after reset.
  - A reset mid-frame aborts the frame; no done or frame_err pulse follows.
- Input synchronisation: data_bit passes through a 2-flop synchroniser, giving rx_s. A previous-value flop gives rx_q. fall = rx_q & ~rx_s.
- Timing variables: cpb_l is CLKS_PER_BIT latched at fall in IDLE. half = cpb_l >> 1. clk_counter is 13 bits. bit_counter is 3 bits.
- IDLE:
  - On fall: latch cpb_l, set clk_counter=0, go to START_BIT.
  - If rx_s is held low (break) without a new fall, stay in IDLE.
- START_BIT:
  - Count clk_counter up to half-1.
  - At clk_counter==half-1, sample rx_s.
  - If rx_s is 0: clk_counter=0, bit_counter=0, go to DATA_BITS.
  - If rx_s is 1 (glitch): return to IDLE silently.
- DATA_BITS:
  - Count to cpb_l-1.
  - At clk_counter==cpb_l-1, sample rx_s into shift register bit[bit_counter] (LSB first) and set clk_counter=0.
  - If bit_counter==7, go to STOP_BIT; otherwise increment bit_counter.
- STOP_BIT:
  - Count to cpb_l-1, then sample rx_s.
  - If 1: load data_bus from the shift register and assert done next cycle.
  - If 0: leave data_bus unchanged and assert frame_err next cycle.
  - In both cases go to DONE.
- DONE: exactly one cycle; done or frame_err is high in this cycle only. Then go to IDLE.
- Latency: let T0 be the first cycle fall is high.
  - Start sample at T0+half.
  - Data bit i sample at T0+half+(i+1)*cpb_l.
  - Stop sample at T0+half+9*cpb_l.
  - done/frame_err high in cycle T0+half+9*cpb_l+1.
  - Pin-to-T0 delay is 2–3 clocks (synchroniser).
- Back-to-back frames:
  - IDLE is re-entered about cpb_l/2 before the nominal stop-bit end.
  - The next start falling edge is detected with no dead time.
  - A stop bit that stays low only re-arms after the line returns high and falls again.
- Runtime changes: CLKS_PER_BIT changes mid-frame are ignored until the next start.
- Odd CLKS_PER_BIT: half truncates, so the sample point is at floor(cpb/2).
- CLKS_PER_BIT < 4: behaviour is unspecified; the bench does not drive it.
- done and frame_err are never high in the same cycle.

Test Plan:
1. CLKS_PER_BIT=16; drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> data_bus=0xA5; done high exactly 1 cycle at T0+153; frame_err stays 0; busy low afterwards.
2. CLKS_PER_BIT=16; low glitch of 4 clocks on an idle line -> returns to IDLE; no done or frame_err; data_bus unchanged.
3. CLKS_PER_BIT=16; frame 0x3C with stop bit held 0 -> frame_err pulses once; done stays 0; data_bus keeps its previous value; no new frame until the line goes high and then falls.
4. CLKS_PER_BIT=433; back-to-back frames 0x00 then 0xFF, each with a 1-bit stop -> two done pulses; data_bus is 0x00 and then 0xFF.
5. CLKS_PER_BIT=16; assert rstn low during data bit 3 of 0x55, release, then send 0x12 -> no pulse for the aborted frame; data_bus=0x00 after reset; 0x12 is received correctly.
6. CLKS_PER_BIT=17; change CLKS_PER_BIT to 40 mid-frame while sending 0x81 -> 0x81 is received at 17-clock timing; the next frame uses 40.
